// File: rtl/in128_out1536_pkg.sv
// Shared widths, the park/accumulate state type and the lane keep-mask helper
// for the 128-to-1536 bit stream packer.
package in128_out1536_pkg;

  localparam int IN_W       = 128;
  localparam int RATIO      = 12;
  localparam int OUT_W      = IN_W * RATIO;
  localparam int LANE_IDX_W = 4;

  localparam logic [RATIO-1:0]      KEEP_FULL = 12'hFFF;
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(RATIO - 1);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_PARKED = 1'b1
  } park_state_t;

  // Lanes 0..lane are valid, so the mask is the full mask shifted down.
  function automatic logic [RATIO-1:0] keepMask(input logic [LANE_IDX_W-1:0] lane);
    return KEEP_FULL >> (LAST_LANE - lane);
  endfunction

endpackage

// File: rtl/in128_out1536_if.sv
// Bundles the narrow input stream and the wide output stream of the packer.
interface in128_out1536_if;
  import in128_out1536_pkg::*;

  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [RATIO-1:0] m_axis_tlast;
  logic [RATIO-1:0] m_axis_tkeep;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep
  );

endinterface

// File: rtl/in128_out1536_pack_acc.sv
// Lane accumulator: places accepted beats into successive 128-bit lanes and
// presents the (possibly partial) completed word, zero above the last lane.
module in128_pack_acc
  import in128_out1536_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_last,
  input  logic             i_clear,
  output logic [OUT_W-1:0] o_word_out,
  output logic [RATIO-1:0] o_word_keep,
  output logic [RATIO-1:0] o_word_last,
  output logic             o_word_complete
);

  logic [OUT_W-1:0]      r_acc;
  logic [RATIO-1:0]      r_acc_last;
  logic [LANE_IDX_W-1:0] r_cnt;

  // Lanes above r_cnt are always zero, so merging the new beat into its lane
  // yields the finished word; a parked word is simply r_acc unchanged.
  always_comb begin
    o_word_out  = r_acc;
    o_word_last = r_acc_last;
    for (int k = 0; k < RATIO; k++) begin
      if (i_accept && (r_cnt == LANE_IDX_W'(k))) begin
        o_word_out[k*IN_W +: IN_W] = i_data;
        o_word_last[k]             = i_last;
      end
    end
    o_word_keep     = keepMask(r_cnt);
    o_word_complete = i_accept & ((r_cnt == LAST_LANE) | i_last);
  end

  // A completing beat that cannot leave keeps r_cnt, so the keep mask of the
  // parked word stays correct until it is cleared.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc      <= '0;
      r_acc_last <= '0;
      r_cnt      <= '0;
    end else if (i_accept) begin
      r_acc      <= o_word_out;
      r_acc_last <= o_word_last;
      if (!o_word_complete) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/in128_out1536.sv
// 128-bit to 1536-bit stream upconverter: lane packing plus a single output
// register, with one completed word able to park in the accumulator.
module in128_out1536
  import in128_out1536_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  in128_out1536_if.slave bus
);

  park_state_t      r_state;
  park_state_t      w_state_next;
  logic             r_s_ready;
  logic             r_m_valid;
  logic [OUT_W-1:0] r_m_data;
  logic [RATIO-1:0] r_m_keep;
  logic [RATIO-1:0] r_m_last;

  logic             w_accept;
  logic             w_out_free;
  logic             w_load;
  logic [OUT_W-1:0] w_word_out;
  logic [RATIO-1:0] w_word_keep;
  logic [RATIO-1:0] w_word_last;
  logic             w_word_complete;

  assign w_accept   = bus.s_axis_tvalid & r_s_ready;
  assign w_out_free = ~r_m_valid | bus.m_axis_tready;

  in128_pack_acc u_pack_acc (
    .clk             (clk),
    .rst             (rst),
    .i_accept        (w_accept),
    .i_data          (bus.s_axis_tdata),
    .i_last          (bus.s_axis_tlast),
    .i_clear         (w_load),
    .o_word_out      (w_word_out),
    .o_word_keep     (w_word_keep),
    .o_word_last     (w_word_last),
    .o_word_complete (w_word_complete)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_word_complete) begin
          if (w_out_free) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_PARKED;
          end
        end
      end
      ST_PARKED: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_state_next = ST_ACCUM;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Input ready mirrors "no word parked" and is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACCUM;
      r_s_ready <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_s_ready <= (w_state_next == ST_ACCUM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_word_out;
      r_m_keep  <= w_word_keep;
      r_m_last  <= w_word_last;
    end else if (bus.m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.s_axis_tready = r_s_ready;
  assign bus.m_axis_tvalid = r_m_valid;
  assign bus.m_axis_tdata  = r_m_data;
  assign bus.m_axis_tkeep  = r_m_keep;
  assign bus.m_axis_tlast  = r_m_last;

endmodule

// File: tb/tb_in128_out1536.sv
// Scoreboard bench for in128_out1536: directed beat sequences push expected
// wide words; a negedge monitor pops and compares each output transfer.
module tb_in128_out1536;
  import in128_out1536_pkg::*;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
    logic [RATIO-1:0] last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  in128_out1536_if bus ();

  in128_out1536 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  word_t            expQ[$];
  longint           wordCycles[$];
  longint           cycle = 0;
  int               vectors = 0;
  int               miscompares = 0;
  int               stalls = 0;
  logic [OUT_W-1:0] mData = '0;
  logic [RATIO-1:0] mLast = '0;
  int               mLane = 0;

  always @(posedge clk) cycle++;

  function automatic logic [IN_W-1:0] beatVal(input int tag);
    return {4{tag}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkWide(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (act[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) bad = k;
    end
    if (bad >= 0) begin
      miscompares++;
      $display("[TB] FAIL %s: lane %0d got %0h, expected %0h", name, bad,
               act[bad*IN_W +: IN_W], exp[bad*IN_W +: IN_W]);
    end
  endtask

  // Expected-word builder: lane placement and flush on lane 11 or tlast.
  task automatic modelBeat(input logic [IN_W-1:0] d, input bit l);
    word_t w;
    mData[mLane*IN_W +: IN_W] = d;
    mLast[mLane] = l;
    if (mLane == RATIO - 1 || l) begin
      w.data = mData;
      w.last = mLast;
      w.keep = '0;
      for (int i = 0; i <= mLane; i++) w.keep[i] = 1'b1;
      expQ.push_back(w);
      mData = '0;
      mLast = '0;
      mLane = 0;
    end else begin
      mLane++;
    end
  endtask

  task automatic applyStimulus(input int tag, input bit l);
    int waitCnt;
    bit ok;
    bus.s_axis_tdata  = beatVal(tag);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = l;
    ok = 0;
    waitCnt = 0;
    while (!ok && waitCnt < 50) begin
      @(negedge clk);
      if (bus.s_axis_tready === 1'b1) ok = 1;
      else begin
        waitCnt++;
        stalls++;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      modelBeat(beatVal(tag), l);
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL beat accept timeout: tag %0d, tready %0b", tag, bus.s_axis_tready);
    end
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic sendBeats(input int start, input int n, input bit lastOnFinal);
    for (int i = 0; i < n; i++) applyStimulus(start + i, lastOnFinal && (i == n - 1));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " m_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput({tag, " s_tready"}, 64'(bus.s_axis_tready), 64'd1);
    checkOutput({tag, " m_tkeep"}, 64'(bus.m_axis_tkeep), 64'd0);
    checkOutput({tag, " m_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    checkWide({tag, " m_tdata"}, bus.m_axis_tdata, '0);
  endtask

  // Monitor: a transfer seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    word_t e;
    if (rst === 1'b0 && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      wordCycles.push_back(cycle);
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected word: keep %0h, expected none", bus.m_axis_tkeep);
      end else begin
        e = expQ.pop_front();
        checkWide("word data", bus.m_axis_tdata, e.data);
        checkOutput("word keep", 64'(bus.m_axis_tkeep), 64'(e.keep));
        checkOutput("word last", 64'(bus.m_axis_tlast), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;

    // Full word, lane k carries tag k; visible one cycle after beat 11.
    sendBeats(0, 12, 1'b0);
    checkOutput("t1 latency tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    checkOutput("t1 keep", 64'(bus.m_axis_tkeep), 64'hFFF);
    checkOutput("t1 last", 64'(bus.m_axis_tlast), 64'h000);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Two back-to-back words: no stall and 12 cycles apart.
    stalls = 0;
    sendBeats(100, 24, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t2 stalls", 64'(stalls), 64'd0);
    n = wordCycles.size();
    if (n >= 2) checkOutput("t2 word spacing", 64'(wordCycles[n-1] - wordCycles[n-2]), 64'd12);
    else checkOutput("t2 word count", 64'(n), 64'd3);

    // Early flush on lane 4, then a single-beat packet.
    sendBeats(200, 5, 1'b1);
    checkOutput("t3 keep", 64'(bus.m_axis_tkeep), 64'h01F);
    checkOutput("t3 last", 64'(bus.m_axis_tlast), 64'h010);
    checkWide("t3 upper lanes zero", bus.m_axis_tdata >> (5 * IN_W), '0);
    idle();
    @(posedge clk);
    #1;
    applyStimulus(210, 1'b1);
    checkOutput("t3 single keep", 64'(bus.m_axis_tkeep), 64'h001);
    checkOutput("t3 single last", 64'(bus.m_axis_tlast), 64'h001);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: word 1 held, word 2 parks, ready drops.
    bus.m_axis_tready = 1'b0;
    sendBeats(300, 24, 1'b0);
    idle();
    checkOutput("t4 s_tready parked", 64'(bus.s_axis_tready), 64'd0);
    checkOutput("t4 held tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    @(posedge clk);
    #1;
    checkWide("t4 held word1", bus.m_axis_tdata & {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}},
              {{(OUT_W-IN_W){1'b0}}, beatVal(300)});
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4 word2 tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    checkOutput("t4 s_tready back", 64'(bus.s_axis_tready), 64'd1);
    checkWide("t4 word2 lane0", bus.m_axis_tdata & {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}},
              {{(OUT_W-IN_W){1'b0}}, beatVal(312)});
    @(posedge clk);
    #1;
    checkOutput("t4 drained tvalid", 64'(bus.m_axis_tvalid), 64'd0);

    // Reset mid-word discards the partial word.
    sendBeats(400, 7, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mData = '0;
    mLast = '0;
    mLane = 0;
    checkResetOutputs("t5 after reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5 no word", 64'(bus.m_axis_tvalid), 64'd0);
    sendBeats(500, 12, 1'b0);
    checkWide("t5 lane0 first beat", bus.m_axis_tdata & {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}},
              {{(OUT_W-IN_W){1'b0}}, beatVal(500)});
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Completing beat lands in the same cycle the held word drains.
    bus.m_axis_tready = 1'b0;
    sendBeats(600, 12, 1'b0);
    sendBeats(612, 11, 1'b0);
    bus.m_axis_tready = 1'b1;
    applyStimulus(623, 1'b0);
    idle();
    checkOutput("t6 new word tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    checkOutput("t6 s_tready", 64'(bus.s_axis_tready), 64'd1);
    checkWide("t6 new word lane0", bus.m_axis_tdata & {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}},
              {{(OUT_W-IN_W){1'b0}}, beatVal(612)});
    @(posedge clk);
    #1;
    checkOutput("t6 s_tready after", 64'(bus.s_axis_tready), 64'd1);
    checkOutput("t6 drained tvalid", 64'(bus.m_axis_tvalid), 64'd0);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/in128_out1536.md
Name: in128_out1536

Overview:
Width upconverter. It packs 128-bit AXI-Stream beats into 1536-bit words of 12 lanes each; lane 0 is the first beat received. A beat with tlast flushes a partial word early. This block is the inverse of the wide-to-narrow downconverter on the accelerator data route, and feeds the 1536-bit wide side from a 128-bit stream. Each lane carries a per-lane tlast bit and a per-lane keep bit.

Parameters:
IN_W, 128, narrow beat width in bits
RATIO, 12, beats per wide word
OUT_W, IN_W*RATIO (1536), wide word width in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
s_axis_tdata  input  128  narrow beat
s_axis_tvalid  input  1  beat valid
s_axis_tready  output  1  block can accept a beat (registered)
s_axis_tlast  input  1  last beat of packet
m_axis_tdata  output  1536  packed word; lane k = bits [128k+127:128k]
m_axis_tvalid  output  1  word valid
m_axis_tready  input  1  downstream accepts word
m_axis_tlast  output  12  bit k set = lane k carried s_axis_tlast
m_axis_tkeep  output  12  bit k set = lane k holds valid data

Behaviour:
- One clock domain; reset is synchronous and active-high.
- State:
  - acc: 1536-bit accumulator plus 12-bit tlast vector.
  - cnt: 4-bit lane index, range 0..11.
  - acc_done: a completed word is parked in acc.
  - out register: drives the m_axis_* outputs.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tkeep=0.
  - s_axis_tready=1, cnt=0, acc=0, acc_done=0.
- An input beat is accepted when s_axis_tvalid & s_axis_tready.
- Accepted beat, not completing a word:
  - Data goes to lane cnt of acc; tlast goes to bit cnt of the acc tlast vector.
  - cnt increments.
- A beat completes a word when cnt==11 or s_axis_tlast=1.
- On a completing beat, the completed word is {new beat at lane cnt, acc lanes 0..cnt-1, zeros above cnt}.
  - tkeep = (1<<(cnt+1))-1.
  - tlast vector = acc vector with bit cnt set to s_axis_tlast.
- out_free = ~m_axis_tvalid | m_axis_tready.
- Completing beat with out_free:
  - The word is written straight into the out register; m_axis_tvalid=1 next cycle.
  - acc is cleared and cnt=0.
  - No bubble results.
- Completing beat without out_free:
  - The word stays in acc (zero-padded) and acc_done=1.
  - s_axis_tready goes 0 on the next cycle.
- acc_done=1 and out_free:
  - acc moves to the out register.
  - acc is cleared, cnt=0, acc_done=0.
  - s_axis_tready returns to 1 on the next cycle.
- s_axis_tready is always ~acc_done, registered.
- m_axis_tvalid:
  - Set when a word loads into the out register.
  - Cleared when m_axis_tready=1 and no new word loads in the same cycle.
  - Output data is held stable while m_axis_tvalid & ~m_axis_tready.
- Latency: the word appears on m_axis one cycle after its final beat is accepted (or after the acc_done transfer).
- Throughput: 1 beat/cycle sustained while m_axis_tready=1; 12 beats per wide word.
- Boundary cases:
  - tlast on lane 11: tkeep=0xFFF, tlast=0x800.
  - tlast on lane 0: tkeep=0x001, lanes 1..11 zero.
  - A tlast beat while acc_done=1 cannot occur, because tready=0.
  - Reset mid-word discards all partial and pending data; the first beat after reset lands in lane 0.
- Unused lanes are always zero. Partial words never carry stale data.

Decomposition:
- Shared package: IN_W, RATIO, OUT_W, LANE_IDX_W=4, KEEP_FULL=12'hFFF.
- Natural sub-module: in128_pack_acc.
  - Owns acc, cnt, the tlast/keep vectors and the completed-word mux.
  - Exposes word_out, word_keep, word_last, word_complete.
- Top level owns acc_done, the out register and the handshakes.

Test Plan:
1. 12 beats, data=k in lane k, m_axis_tready=1, no tlast -> one word, lane k=k, tkeep=0xFFF, tlast=0x000, tvalid one cycle after beat 11.
2. 24 back-to-back beats, m_axis_tready=1 -> s_axis_tready stays 1; two words on consecutive 12-cycle boundaries with no bubble.
3. 5 beats, tlast on beat 4 -> tkeep=0x01F, tlast=0x010, lanes 5..11 all zero. Then a single tlast beat -> tkeep=0x001, tlast=0x001.
4. m_axis_tready=0, send 24 beats:
   - word 1 is held on m_axis and word 2 parks in acc;
   - s_axis_tready=0 the cycle after beat 24;
   - raise m_axis_tready -> word 1, then word 2 on the next cycle; s_axis_tready=1 one cycle after word 2 loads.
5. 7 beats, rst pulsed for 1 cycle -> no output word and all outputs at reset values. Then 12 beats -> a clean word with lane 0 = first beat after reset.
6. Completing beat arrives in the same cycle the out register drains (tvalid&tready) -> the new word appears the next cycle; acc_done never set.
